bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Parametrised multi-digit BCD countdown timer built from a chain of borrow-linked digit cells. Loads a clamped BCD preset, counts down one unit per time-base tick while running, and flags expiry with a one-cycle `done` pulse plus a sticky `expired` level. It sits between the 1 Hz tick generator and the pattern-matching control FSM. It replaces hand-chained single-digit timers with one block of configurable width and added start/pause/reload control.

## Interface
- `NUM_DIGITS`, default 2: number of BCD digits (1..8); digit 0 is least significant.
- `W`, derived as 4*NUM_DIGITS: width of the preset and count buses.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `tick`, input, 1: time-base enable, one `clk` cycle wide per count unit.
- `load`, input, 1: capture `preset` into the count and reload registers.
- `preset`, input, W: BCD preset; any nibble >9 clamps to 9.
- `start`, input, 1: begin or resume counting.
- `pause`, input, 1: suspend counting and hold the count.
- `auto_reload`, input, 1: at expiry, reload the stored preset and keep running (see Configuration).
- `count`, output, W: current BCD value.
- `running`, output, 1: high in state RUN.
- `expired`, output, 1: high in state EXPIRED.
- `done`, output, 1: one-cycle pulse on every expiry, including reload expiries.
- `preset_err`, output, 1: registered; high for one cycle after a `load` in which any nibble was clamped.

## Operation
- Reset: state IDLE; `count` and the reload register are all digits 9 (`{NUM_DIGITS{4'h9}}`); `running`, `expired`, `done` and `preset_err` are all 0.
- States:
  - IDLE: hold the count. `start` moves to RUN if count ≠ 0, otherwise to EXPIRED with `done`.
  - RUN: count down on `tick`. `pause` moves to PAUSE. Reaching zero moves to EXPIRED, or stays in RUN with a reload when auto-reload applies.
  - PAUSE: hold the count and ignore `tick`. `start` moves back to RUN.
  - EXPIRED: count held at 0. `start` has no effect; only `load` leaves this state.
- `load` from any state: count and reload register take the clamped `preset`, and the state goes to IDLE.
- Decrement rule, applied on `tick` in RUN:
  - Digit i decrements when digits 0..i-1 are all zero (borrow chain).
  - A digit at 0 that receives a borrow wraps to 9.
  - The all-zero value is never decremented.
- Expiry: a `tick` in RUN with count == 1 (LSD 1, all other digits 0) gives count 0 next cycle, `done` = 1 that cycle, and state EXPIRED.
- Priority within one cycle: `load` > `pause` > `start` > `tick`. A `tick` coinciding with `pause` is dropped.

## Timing
- Every output is registered. `count` changes in the cycle after the sampled `tick`.
- `done` is asserted in the same cycle the count first shows 0, or shows the reloaded value.
- `start` with a nonzero count: `running` goes high the next cycle, and a `tick` in that next cycle is counted.
- Back-to-back ticks (`tick` held high) decrement once per cycle.
- A `tick` in the same cycle as `start` is ignored, because the state is not yet RUN.
- `rst` asserted mid-count: all outputs take their reset values immediately, with no clock needed; release is synchronised by the surrounding design.

## Configuration
- `TIMER_AUTORELOAD_EN` defined:
  - If `auto_reload` = 1 at expiry, count takes the reload register value instead of 0 and state stays RUN; `done` still pulses.
  - A zero reload value goes to EXPIRED.
- Not defined: `auto_reload` is ignored, the block is strictly one-shot, and no reload register is built. The reset-value rule for the reload register then does not apply.

## Structure
- Package `timer_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE, EXPIRED);
  - `BCD_MAX` = 4'h9 and `BCD_ZERO` = 4'h0;
  - the clamp function for one nibble.
- Sub-module `bcd_digit_cell`, instantiated NUM_DIGITS times via generate:
  - inputs: `clk`, `rst`, `load`, `load_val`, `dec_en`, `borrow_in`;
  - outputs: `digit`, `is_zero`, `borrow_out`.
- The top level keeps the FSM, the zero-detect AND of the `is_zero` outputs, the reload register and `preset_err`.

## Test plan
- Reset with all inputs low: `count` = 8'h99, `running`, `expired`, `done` = 0. Asserting `rst` in mid-RUN forces the same values asynchronously.
- `load` with `preset` = 8'h3C: `count` = 8'h39 and `preset_err` pulses once.
- Load 8'h10, `start`, then one `tick`: count goes 8'h10 → 8'h09 (borrow wrap). Ten more ticks: count = 8'h00, `done` pulses once, `expired` = 1.
- Load 8'h05, `start`, two ticks (count 8'h03), `pause` held with three ticks: count stays 8'h03. Then `start` and three ticks: expiry on the third tick.
- `pause`, `start` and `tick` all asserted in one cycle while in RUN: state PAUSE, count unchanged. `load` together with `start`: state IDLE with the loaded value.
- With `TIMER_AUTORELOAD_EN` defined: load 8'h02, `start`, `auto_reload` = 1, four ticks: count sequence 01, 02, 01, 02; `done` pulses twice; `expired` stays 0.

Source files
------------

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'h9;
  localparam logic [3:0] BCD_ZERO = 4'h0;

  function automatic logic [3:0] clamp_nibble(input logic [3:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between the timer and its controller.
interface bcd_countdown_timer_if #(parameter int NUM_DIGITS = 2);
  logic                    tick;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] preset;
  logic                    start;
  logic                    pause;
  logic                    auto_reload;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    running;
  logic                    expired;
  logic                    done;
  logic                    preset_err;

  modport master (
    output tick, load, preset, start, pause, auto_reload,
    input  count, running, expired, done, preset_err
  );

  modport slave (
    input  tick, load, preset, start, pause, auto_reload,
    output count, running, expired, done, preset_err
  );
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the countdown chain; wraps 0 -> 9 when borrowed from.
module bcd_digit_cell
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       is_zero,
  output logic       borrow_out
);

  logic [3:0] digit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= BCD_MAX;
    end else if (load) begin
      digit_q <= load_val;
    end else if (dec_en && borrow_in) begin
      digit_q <= (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  assign digit      = digit_q;
  assign is_zero    = (digit_q == BCD_ZERO);
  assign borrow_out = borrow_in & is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with start/pause/load control.
// Optional auto-reload at expiry is built when TIMER_AUTORELOAD_EN is defined.
//   state   | meaning
//   IDLE    | loaded or reset, waiting for start
//   RUN     | counting down on tick
//   PAUSE   | count held, ticks ignored
//   EXPIRED | count reached zero, only load leaves
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_countdown_timer_if.slave  bus
);

  localparam int W = 4 * NUM_DIGITS;

  state_e                 state_q;
  logic                   running_q, expired_q, done_q, preset_err_q;
  logic [W-1:0]           preset_cl;
  logic                   clamp_hit;
  logic [W-1:0]           count_w;
  logic [NUM_DIGITS-1:0]  is_zero;
  logic [NUM_DIGITS:0]    borrow;
  logic                   all_zero, count_is_one, run_tick;
  logic                   do_reload, cell_load, dec_en;
  logic [W-1:0]           cell_val;
  logic                   unused_borrow_top;

  always_comb begin
    preset_cl = '0;
    clamp_hit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      preset_cl[4*i +: 4] = clamp_nibble(bus.preset[4*i +: 4]);
      clamp_hit = clamp_hit | (bus.preset[4*i +: 4] > BCD_MAX);
    end
  end

  assign all_zero          = &is_zero;
  assign count_is_one      = (count_w == W'(1));
  assign run_tick          = (state_q == RUN) && bus.tick && !bus.load && !bus.pause && !all_zero;
  assign unused_borrow_top = borrow[NUM_DIGITS];

`ifdef TIMER_AUTORELOAD_EN
  logic [W-1:0] reload_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= {NUM_DIGITS{BCD_MAX}};
    end else if (bus.load) begin
      reload_q <= preset_cl;
    end
  end

  // A zero reload value would re-expire forever, so it falls through to EXPIRED.
  assign do_reload = run_tick && count_is_one && bus.auto_reload && (reload_q != '0);
  assign cell_val  = bus.load ? preset_cl : reload_q;
`else
  logic unused_auto_reload;
  assign unused_auto_reload = bus.auto_reload;
  assign do_reload          = 1'b0;
  assign cell_val           = preset_cl;
`endif

  assign cell_load = bus.load | do_reload;
  assign dec_en    = run_tick & ~do_reload;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .load       (cell_load),
      .load_val   (cell_val[4*i +: 4]),
      .dec_en     (dec_en),
      .borrow_in  (borrow[i]),
      .digit      (count_w[4*i +: 4]),
      .is_zero    (is_zero[i]),
      .borrow_out (borrow[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      running_q    <= 1'b0;
      expired_q    <= 1'b0;
      done_q       <= 1'b0;
      preset_err_q <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      preset_err_q <= bus.load & clamp_hit;
      if (bus.load) begin
        state_q   <= IDLE;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start && !bus.pause) begin
              if (all_zero) begin
                state_q   <= EXPIRED;
                expired_q <= 1'b1;
                done_q    <= 1'b1;
              end else begin
                state_q   <= RUN;
                running_q <= 1'b1;
              end
            end
          end
          RUN: begin
            if (bus.pause) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end else if (run_tick && count_is_one) begin
              done_q <= 1'b1;
              if (!do_reload) begin
                state_q   <= EXPIRED;
                running_q <= 1'b0;
                expired_q <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (bus.start && !bus.pause) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.count      = count_w;
  assign bus.running    = running_q;
  assign bus.expired    = expired_q;
  assign bus.done       = done_q;
  assign bus.preset_err = preset_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Table-driven self-checking bench for bcd_countdown_timer (NUM_DIGITS = 2).
module tb_bcd_countdown_timer;

  typedef struct {
    logic       tick;
    logic       load;
    logic [7:0] preset;
    logic       start;
    logic       pause;
    logic       ar;
    logic [7:0] cnt;
    logic       run;
    logic       exp;
    logic       dn;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vec_t vecs[$];
  vec_t sb[$];

  bcd_countdown_timer_if #(.NUM_DIGITS(2)) bus ();

  bcd_countdown_timer #(.NUM_DIGITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic tk, logic ld, logic [7:0] pre, logic st, logic pa, logic ar,
                              logic [7:0] cnt, logic run, logic exp, logic dn, logic err);
    vec_t v;
    v.tick = tk; v.load = ld; v.preset = pre; v.start = st; v.pause = pa; v.ar = ar;
    v.cnt = cnt; v.run = run; v.exp = exp; v.dn = dn; v.err = err;
    return v;
  endfunction

  task automatic check_out(input string name, input vec_t e);
    checks++;
    if ({bus.count, bus.running, bus.expired, bus.done, bus.preset_err} !==
        {e.cnt, e.run, e.exp, e.dn, e.err}) begin
      errors++;
      $display("FAIL %s: got count=%h run=%b exp=%b done=%b err=%b, want count=%h run=%b exp=%b done=%b err=%b",
               name, bus.count, bus.running, bus.expired, bus.done, bus.preset_err,
               e.cnt, e.run, e.exp, e.dn, e.err);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.tick = v.tick; bus.load = v.load; bus.preset = v.preset;
    bus.start = v.start; bus.pause = v.pause; bus.auto_reload = v.ar;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    drive(v);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_out($sformatf("vec[%0d]", idx), e);
  endtask

  initial begin
    // tick, load, preset, start, pause, ar | count, running, expired, done, preset_err
    vecs.push_back(mk(0,1,8'h3C,0,0,0, 8'h39,0,0,0,1));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 8'h39,0,0,0,0));
    vecs.push_back(mk(0,1,8'h10,0,0,0, 8'h10,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1,0,0, 8'h10,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h09,1,0,0,0));
    for (int k = 8; k >= 1; k--)
      vecs.push_back(mk(1,0,8'h00,0,0,0, 8'(k),1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h00,0,1,1,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h00,0,1,0,0));
    vecs.push_back(mk(0,0,8'h00,1,0,0, 8'h00,0,1,0,0));
    // pause holds through ticks, then resume to expiry
    vecs.push_back(mk(0,1,8'h05,0,0,0, 8'h05,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1,0,0, 8'h05,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h04,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h03,1,0,0,0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,0,8'h00,0,1,0, 8'h03,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1,0,0, 8'h03,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h02,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h01,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h00,0,1,1,0));
    // priority corners
    vecs.push_back(mk(0,1,8'h20,0,0,0, 8'h20,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1,0,0, 8'h20,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h19,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,1,1,0, 8'h19,0,0,0,0));
    vecs.push_back(mk(0,1,8'h42,1,0,0, 8'h42,0,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h42,0,0,0,0));
    vecs.push_back(mk(1,0,8'h00,1,0,0, 8'h42,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h41,1,0,0,0));
    // zero preset expires straight from start
    vecs.push_back(mk(0,1,8'h00,0,0,0, 8'h00,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1,0,0, 8'h00,0,1,1,0));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 8'h00,0,1,0,0));
    // clamp of the low nibble, then back-to-back ticks
    vecs.push_back(mk(0,1,8'h9F,0,0,0, 8'h99,0,0,0,1));
    vecs.push_back(mk(0,0,8'h00,1,0,0, 8'h99,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h98,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h97,1,0,0,0));
`ifdef TIMER_AUTORELOAD_EN
    vecs.push_back(mk(0,1,8'h02,0,0,0, 8'h02,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1,0,1, 8'h02,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,1, 8'h01,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,1, 8'h02,1,0,1,0));
    vecs.push_back(mk(1,0,8'h00,0,0,1, 8'h01,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,1, 8'h02,1,0,1,0));
`else
    vecs.push_back(mk(0,1,8'h02,0,0,0, 8'h02,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1,0,1, 8'h02,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,1, 8'h01,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,1, 8'h00,0,1,1,0));
    vecs.push_back(mk(1,0,8'h00,0,0,1, 8'h00,0,1,0,0));
`endif
    vecs.push_back(mk(0,1,8'h57,0,0,0, 8'h57,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,1,0,0, 8'h57,1,0,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 8'h56,1,0,0,0));

    drive(mk(0,0,8'h00,0,0,0, 8'h00,0,0,0,0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", mk(0,0,8'h00,0,0,0, 8'h99,0,0,0,0));
    rst = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // asynchronous reset mid-RUN, sampled before any further clock edge
    drive(mk(1,0,8'h00,0,0,0, 8'h00,0,0,0,0));
    #1;
    rst = 1'b1;
    #1;
    check_out("async_rst", mk(0,0,8'h00,0,0,0, 8'h99,0,0,0,0));
    drive(mk(0,0,8'h00,0,0,0, 8'h00,0,0,0,0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_out("post_rst", mk(0,0,8'h00,0,0,0, 8'h99,0,0,0,0));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
